// File: rtl/cte_pkg.sv
// rtl/cte_pkg.sv - shared constants, serializer states and saturation helper for the RGB->YUV422 stream
// Purpose: coefficient base values (scaled by 2^8), a rescaler to any fraction width,
//          the serializer state enum and a generic signed saturation function.
// Ports:   none (package).
package cte_pkg;

  // Coefficients as integers scaled by 2^COEF_FRAC.
  localparam int COEF_FRAC = 8;
  localparam int CY_R = 77;
  localparam int CY_G = 150;
  localparam int CY_B = 29;
  localparam int CU_R = -43;
  localparam int CU_G = -85;
  localparam int CU_B = 128;
  localparam int CV_R = 128;
  localparam int CV_G = -107;
  localparam int CV_B = -21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_U,
    ST_Y0,
    ST_V,
    ST_Y1
  } ser_state_t;

  // Rescale a base coefficient to 'frac' fractional bits (round half up when narrowing).
  function automatic int scale_coef(input int c, input int frac);
    if (frac >= COEF_FRAC) begin
      return c * (1 << (frac - COEF_FRAC));
    end
    return (c + (1 << (COEF_FRAC - frac - 1))) >>> (COEF_FRAC - frac);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input logic signed [63:0] lo,
                                             input logic signed [63:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/cte_sync_fifo.sv
// rtl/cte_sync_fifo.sv - synchronous FIFO with registered storage and occupancy count
// Purpose: holds computed pixel pairs between the compute stage and the serializer.
// Ports:   clk, reset (sync, active-high); push/wdata write side; pop/rdata read side
//          (rdata shows the head entry directly from storage); empty; count (occupancy).
module cte_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full, do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cte_rgb2yuv422_stream.sv
// rtl/cte_rgb2yuv422_stream.sv - RGB pixel stream to serial 4:2:2 YUV (U,Y0,V,Y1)
// Purpose: pairs incoming RGB pixels, converts each pair to U/Y0/V/Y1 in fixed point,
//          queues results in a FIFO guarded by slot credits and serializes one component
//          per cycle.
// Ports:   clk, reset (sync, active-high); in_en/rgb_in pixel input ({R,G,B}, R in MSBs),
//          accepted when in_en & !busy; flush completes a half pair; busy backpressure;
//          out_valid/yuv_out serial component output (Y unsigned, U/V two's complement).
module cte_rgb2yuv422_stream
  import cte_pkg::*;
#(
  parameter int W          = 8,
  parameter int FRAC       = 8,
  parameter int DEPTH      = 4,
  parameter int CHROMA_AVG = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_en,
  input  logic [3*W-1:0] rgb_in,
  input  logic           flush,
  output logic           busy,
  output logic           out_valid,
  output logic [W-1:0]   yuv_out
);

  localparam int KYR = scale_coef(CY_R, FRAC);
  localparam int KYG = scale_coef(CY_G, FRAC);
  localparam int KYB = scale_coef(CY_B, FRAC);
  localparam int KUR = scale_coef(CU_R, FRAC);
  localparam int KUG = scale_coef(CU_G, FRAC);
  localparam int KUB = scale_coef(CU_B, FRAC);
  localparam int KVR = scale_coef(CV_R, FRAC);
  localparam int KVG = scale_coef(CV_G, FRAC);
  localparam int KVB = scale_coef(CV_B, FRAC);

  localparam logic signed [63:0] RND   = 64'sd1 <<< (FRAC - 1);
  localparam logic signed [63:0] Y_MAX = (64'sd1 <<< W) - 64'sd1;
  localparam logic signed [63:0] C_MIN = -(64'sd1 <<< (W - 1));
  localparam logic signed [63:0] C_MAX = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam int CW = $clog2(DEPTH + 1);

  // Full-precision dot product, round half up (arithmetic shift floors), then saturate.
  function automatic logic [W-1:0] conv(input logic [3*W-1:0] px, input int kr, input int kg,
                                        input int kb, input logic is_chroma);
    logic signed [63:0] sum, q, s;
    sum = 64'(kr) * $signed({{(64-W){1'b0}}, px[3*W-1 -: W]})
        + 64'(kg) * $signed({{(64-W){1'b0}}, px[2*W-1 -: W]})
        + 64'(kb) * $signed({{(64-W){1'b0}}, px[W-1 -: W]});
    q = (sum + RND) >>> FRAC;
    s = is_chroma ? sat(q, C_MIN, C_MAX) : sat(q, 64'sd0, Y_MAX);
    return W'(s);
  endfunction

  function automatic logic [W-1:0] avg(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + (W+1)'(1);
    return W'(s >> 1);
  endfunction

  // ---------------- pair capture ----------------
  logic [3*W-1:0] pix0_q, pair0_q, pair1_q;
  logic           half_q, pair_vld_q, accept;

  assign accept = in_en && !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix0_q     <= '0;
      pair0_q    <= '0;
      pair1_q    <= '0;
      half_q     <= 1'b0;
      pair_vld_q <= 1'b0;
    end else begin
      pair_vld_q <= 1'b0;
      if (accept && half_q) begin
        pair0_q    <= pix0_q;
        pair1_q    <= rgb_in;
        pair_vld_q <= 1'b1;
        half_q     <= 1'b0;
      end else if (accept && flush) begin
        // New pixel 0 taken, then flush duplicates it into pixel 1 in the same edge.
        pair0_q    <= rgb_in;
        pair1_q    <= rgb_in;
        pair_vld_q <= 1'b1;
      end else if (accept) begin
        pix0_q <= rgb_in;
        half_q <= 1'b1;
      end else if (flush && half_q) begin
        pair0_q    <= pix0_q;
        pair1_q    <= pix0_q;
        pair_vld_q <= 1'b1;
        half_q     <= 1'b0;
      end
    end
  end

  // ---------------- compute stage ----------------
  logic [3*W-1:0] chroma_px;
  logic [W-1:0]   u_d, y0_d, v_d, y1_d;
  logic [4*W-1:0] c_data_q;
  logic           c_vld_q;

  always_comb begin
    chroma_px = pair0_q;
    if (CHROMA_AVG != 0) begin
      for (int c = 0; c < 3; c++) begin
        chroma_px[c*W +: W] = avg(pair0_q[c*W +: W], pair1_q[c*W +: W]);
      end
    end
  end

  assign u_d  = conv(chroma_px, KUR, KUG, KUB, 1'b1);
  assign v_d  = conv(chroma_px, KVR, KVG, KVB, 1'b1);
  assign y0_d = conv(pair0_q, KYR, KYG, KYB, 1'b0);
  assign y1_d = conv(pair1_q, KYR, KYG, KYB, 1'b0);

  always_ff @(posedge clk) begin
    if (reset) begin
      c_vld_q  <= 1'b0;
      c_data_q <= '0;
    end else begin
      c_vld_q <= pair_vld_q;
      if (pair_vld_q) c_data_q <= {u_d, y0_d, v_d, y1_d};
    end
  end

  // ---------------- result FIFO and credits ----------------
  logic [4*W-1:0] fifo_rdata;
  logic           fifo_empty, fifo_pop;
  logic [CW-1:0]  fifo_count;
  logic [CW+1:0]  reserved;

  cte_sync_fifo #(.WIDTH(4*W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (c_vld_q),
    .wdata (c_data_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Every pair from its pixel 0 onwards owns a FIFO slot, so the FIFO cannot overflow.
  // Pixel 1 is never blocked: its slot was reserved with pixel 0.
  assign reserved = (CW+2)'(fifo_count) + (CW+2)'(pair_vld_q) + (CW+2)'(c_vld_q)
                  + (CW+2)'(half_q);
  assign busy     = !half_q && (reserved >= (CW+2)'(DEPTH));

  // ---------------- serializer ----------------
  ser_state_t     state_q, state_d;
  logic [3*W-1:0] hold_q, hold_d;
  logic [W-1:0]   yuv_q, yuv_d;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    yuv_d    = yuv_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE, ST_Y1: begin
        if (!fifo_empty) begin
          state_d  = ST_U;
          fifo_pop = 1'b1;
          yuv_d    = fifo_rdata[4*W-1 -: W];
          hold_d   = fifo_rdata[3*W-1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_U: begin
        state_d = ST_Y0;
        yuv_d   = hold_q[3*W-1 -: W];
      end
      ST_Y0: begin
        state_d = ST_V;
        yuv_d   = hold_q[2*W-1 -: W];
      end
      ST_V: begin
        state_d = ST_Y1;
        yuv_d   = hold_q[W-1 -: W];
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      yuv_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      yuv_q   <= yuv_d;
    end
  end

  assign out_valid = (state_q != ST_IDLE);
  assign yuv_out   = yuv_q;

endmodule

// File: tb/tb_cte_rgb2yuv422_stream.sv
// tb/tb_cte_rgb2yuv422_stream.sv - scoreboard bench for cte_rgb2yuv422_stream
// Purpose: drives two instances (a: DEPTH=4 pixel-0 chroma, b: DEPTH=2 averaged chroma),
//          predicts output words with an arithmetic model and checks them in monitors.
// Ports:   none (top-level bench).
module tb_cte_rgb2yuv422_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_en, flush;
  logic [23:0] rgb_in [2];
  logic        busy_a, busy_b, ov_a, ov_b;
  logic [7:0]  yuv_a, yuv_b;
  logic [1:0]  busy, out_valid;
  logic [7:0]  yuv_out [2];

  always #5 clk = ~clk;

  assign busy       = {busy_b, busy_a};
  assign out_valid  = {ov_b, ov_a};
  assign yuv_out[0] = yuv_a;
  assign yuv_out[1] = yuv_b;

  cte_rgb2yuv422_stream #(.W(8), .FRAC(8), .DEPTH(4), .CHROMA_AVG(0)) dut_a (
    .clk(clk), .reset(reset), .in_en(in_en[0]), .rgb_in(rgb_in[0]), .flush(flush[0]),
    .busy(busy_a), .out_valid(ov_a), .yuv_out(yuv_a));

  cte_rgb2yuv422_stream #(.W(8), .FRAC(8), .DEPTH(2), .CHROMA_AVG(1)) dut_b (
    .clk(clk), .reset(reset), .in_en(in_en[1]), .rgb_in(rgb_in[1]), .flush(flush[1]),
    .busy(busy_b), .out_valid(ov_b), .yuv_out(yuv_b));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];
  logic [23:0] pend_px [2];
  bit          pend [2];
  bit          use_model;
  int          out_cnt [2];
  int          busy_cycles, total_cycles;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] comp(input int r, input int g, input int b, input int kr,
                                      input int kg, input int kb, input bit chroma);
    int n, q;
    n = kr * r + kg * g + kb * b + 128;
    q = n / 256;
    if (n < 0 && (n % 256) != 0) q = q - 1;
    if (chroma) begin
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
    end else begin
      if (q > 255) q = 255;
      if (q < 0)   q = 0;
    end
    return 8'(q);
  endfunction

  task automatic push_exp(input int d, input logic [7:0] w);
    if (d == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  task automatic emit(input int d, input logic [23:0] a, input logic [23:0] b);
    int ra, ga, ba, rb, gb, bb, cr, cg, cb;
    ra = a[23:16]; ga = a[15:8]; ba = a[7:0];
    rb = b[23:16]; gb = b[15:8]; bb = b[7:0];
    if (d == 1) begin
      cr = (ra + rb + 1) / 2; cg = (ga + gb + 1) / 2; cb = (ba + bb + 1) / 2;
    end else begin
      cr = ra; cg = ga; cb = ba;
    end
    if (use_model) begin
      push_exp(d, comp(cr, cg, cb, -43, -85, 128, 1'b1));
      push_exp(d, comp(ra, ga, ba, 77, 150, 29, 1'b0));
      push_exp(d, comp(cr, cg, cb, 128, -107, -21, 1'b1));
      push_exp(d, comp(rb, gb, bb, 77, 150, 29, 1'b0));
    end
  endtask

  task automatic model_accept(input int d, input logic [23:0] px, input bit fl);
    if (pend[d]) begin
      emit(d, pend_px[d], px);
      pend[d] = 1'b0;
    end else if (fl) begin
      emit(d, px, px);
    end else begin
      pend[d]    = 1'b1;
      pend_px[d] = px;
    end
  endtask

  // ---------------- stimulus helpers (entered and left at negedge) ----------------
  task automatic send(input int d, input logic [23:0] px, input bit fl);
    int guard = 0;
    if (pend[d]) check("pixel1_not_blocked", 32'(busy[d]), 32'd0);
    in_en[d]  = 1'b1;
    rgb_in[d] = px;
    flush[d]  = fl;
    while (busy[d] && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: dut %0d busy for %0d cycles, required release", d, guard);
    end
    busy_cycles  += guard;
    total_cycles += guard + 1;
    @(negedge clk);
    model_accept(d, px, fl);
    flush[d] = 1'b0;
  endtask

  task automatic idle(input int d);
    in_en[d] = 1'b0;
    flush[d] = 1'b0;
  endtask

  task automatic do_flush(input int d);
    in_en[d] = 1'b0;
    flush[d] = 1'b1;
    @(negedge clk);
    flush[d] = 1'b0;
    if (pend[d]) begin
      emit(d, pend_px[d], pend_px[d]);
      pend[d] = 1'b0;
    end
  endtask

  task automatic drain(input int d);
    int guard = 0;
    while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_left", 32'((d == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
    repeat (2) @(negedge clk);
    check("idle_out_valid", 32'(out_valid[d]), 32'd0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!reset && out_valid[0]) begin
      out_cnt[0]++;
      if (exp_q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL yuv_a_unexpected: got word %0h, required no output", yuv_out[0]);
      end else begin
        check("yuv_a", 32'(yuv_out[0]), 32'(exp_q0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid[1]) begin
      out_cnt[1]++;
      if (exp_q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL yuv_b_unexpected: got word %0h, required no output", yuv_out[1]);
      end else begin
        check("yuv_b", 32'(yuv_out[1]), 32'(exp_q1.pop_front()));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int c0, pct, guard;
    logic [23:0] px;
    reset     = 1'b1;
    in_en     = '0;
    flush     = '0;
    rgb_in[0] = '0;
    rgb_in[1] = '0;
    pend[0]   = 1'b0;
    pend[1]   = 1'b0;
    out_cnt[0] = 0;
    out_cnt[1] = 0;
    use_model = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_busy", 32'(busy[d]), 32'd0);
      check("reset_out_valid", 32'(out_valid[d]), 32'd0);
      check("reset_yuv", 32'(yuv_out[d]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // White pair, with first-output latency measured from the pixel-1 accept edge.
    push_exp(0, 8'h00); push_exp(0, 8'hFF); push_exp(0, 8'h00); push_exp(0, 8'hFF);
    send(0, 24'hFFFFFF, 1'b0);
    send(0, 24'hFFFFFF, 1'b0);
    idle(0);
    check("latency_e0", 32'(out_valid[0]), 32'd0);
    @(negedge clk); check("latency_e1", 32'(out_valid[0]), 32'd0);
    @(negedge clk); check("latency_e2", 32'(out_valid[0]), 32'd0);
    @(negedge clk); check("latency_e3", 32'(out_valid[0]), 32'd1);
    drain(0);

    // Black pair, then red pair (V saturates, U rounds down).
    repeat (4) push_exp(0, 8'h00);
    send(0, 24'h000000, 1'b0);
    send(0, 24'h000000, 1'b0);
    push_exp(0, 8'hD5); push_exp(0, 8'h4D); push_exp(0, 8'h7F); push_exp(0, 8'h4D);
    send(0, 24'hFF0000, 1'b0);
    send(0, 24'hFF0000, 1'b0);
    idle(0);
    drain(0);

    // Averaged chroma on instance b.
    push_exp(1, 8'hEB); push_exp(1, 8'h4D); push_exp(1, 8'h40); push_exp(1, 8'h00);
    send(1, 24'hFF0000, 1'b0);
    send(1, 24'h000000, 1'b0);
    idle(1);
    drain(1);

    use_model = 1'b1;

    // Sustained input on DEPTH=2: every pixel converted, busy near half the time.
    c0 = out_cnt[1];
    busy_cycles = 0;
    total_cycles = 0;
    for (int i = 0; i < 500; i++) send(1, 24'($urandom), 1'b0);
    idle(1);
    drain(1);
    check("stream_word_count", 32'(out_cnt[1] - c0), 32'd1000);
    pct = (busy_cycles * 100) / total_cycles;
    check("busy_duty_40_60", 32'(pct >= 40 && pct <= 60), 32'd1);

    // Random pixels, gaps and flushes on instance a.
    for (int i = 0; i < 150; i++) begin
      send(0, 24'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        idle(0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if ($urandom_range(0, 9) == 0) do_flush(0);
    end
    do_flush(0);
    idle(0);
    drain(0);

    // Three pixels then flush: two pairs, second one duplicated.
    c0 = out_cnt[0];
    for (int i = 0; i < 3; i++) send(0, 24'($urandom), 1'b0);
    do_flush(0);
    idle(0);
    drain(0);
    check("flush_odd_count", 32'(out_cnt[0] - c0), 32'd8);

    // Flush with nothing pending produces nothing.
    c0 = out_cnt[0];
    do_flush(0);
    repeat (10) @(negedge clk);
    check("flush_idle_count", 32'(out_cnt[0] - c0), 32'd0);

    // Flush alongside an accepted fresh pixel makes a duplicated pair.
    c0 = out_cnt[0];
    send(0, 24'h123456, 1'b1);
    idle(0);
    drain(0);
    check("flush_with_pixel_count", 32'(out_cnt[0] - c0), 32'd4);

    // Reset with a half pair pending while the serializer is mid-pair.
    send(0, 24'($urandom), 1'b0);
    send(0, 24'($urandom), 1'b0);
    idle(0);
    guard = 0;
    while (!out_valid[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("reset_test_started", 32'(out_valid[0]), 32'd1);
    send(0, 24'hABCDEF, 1'b0);
    idle(0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid[0]), 32'd0);
    check("midreset_busy", 32'(busy[0]), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    c0 = out_cnt[0];
    px = 24'($urandom);
    send(0, px, 1'b0);
    send(0, 24'($urandom), 1'b0);
    idle(0);
    drain(0);
    check("post_reset_pair_count", 32'(out_cnt[0] - c0), 32'd4);

    check("final_queue_a", 32'(exp_q0.size()), 32'd0);
    check("final_queue_b", 32'(exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
